config_chain_loader: RTL

- Per-tile configuration loader that sits directly upstream of the switch box and drives its 24-bit config_in bus.
- Accepts the bitstream in DATA_WIDTH-bit beats over a valid/ready handshake and collects them in a shadow shift register.
- Commits the full word atomically to a held config register, so the switch box never sees partial configuration.
- Shifted-out bits leave on chain_out so loaders can be daisy-chained tile to tile.

---
 rtl/kfpga_config_pkg.sv | 17 +
 rtl/config_shift_register.sv | 37 +++
 rtl/config_chain_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/kfpga_config_pkg.sv
// Shared definitions for the tile configuration loader and the switch box it feeds.
package kfpga_config_pkg;

  localparam int unsigned SB_CONFIG_WIDTH = 24;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCommit,
    StDone
  } loader_state_e;

  function automatic int unsigned beats(input int unsigned cw, input int unsigned dw);
    return cw / dw;
  endfunction

endpackage

// File: rtl/config_shift_register.sv
// Shadow shift register: new beats enter at the MSB end, old bits leave at the LSB end.
module config_shift_register #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned SHIFT_WIDTH = 1
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   clear,
  input  logic                   shift_en,
  input  logic [SHIFT_WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]       shadow,
  output logic [SHIFT_WIDTH-1:0] shift_out
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shifted;

  if (WIDTH > SHIFT_WIDTH) begin : g_shift
    assign shifted = {data_in, shadow_q[WIDTH-1:SHIFT_WIDTH]};
  end else begin : g_single
    assign shifted = data_in;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      shadow_q <= '0;
    end else if (clear) begin
      shadow_q <= '0;
    end else if (shift_en) begin
      shadow_q <= shifted;
    end
  end

  assign shadow    = shadow_q;
  assign shift_out = shadow_q[SHIFT_WIDTH-1:0];

endmodule

// File: rtl/config_chain_loader.sv
// Per-tile configuration loader: collects beats into a shadow register and commits the
// whole word atomically to config_out; displaced shadow bits go out on chain_out.
module config_chain_loader
  import kfpga_config_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = SB_CONFIG_WIDTH,
  parameter int unsigned DATA_WIDTH   = 1
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [DATA_WIDTH-1:0]   chain_out,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    config_done,
  output logic                    busy
);

  localparam int unsigned BEATS = beats(CONFIG_WIDTH, DATA_WIDTH);
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  if (CONFIG_WIDTH % DATA_WIDTH != 0) begin : g_bad_width
    $error("CONFIG_WIDTH must be a multiple of DATA_WIDTH");
  end

  loader_state_e           state_q;
  logic [CNT_W-1:0]        count_q;
  logic [DATA_WIDTH-1:0]   chain_q;
  logic [CONFIG_WIDTH-1:0] config_q;
  logic                    done_q;
  logic                    busy_q;
  logic                    ready_q;

  logic [CONFIG_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0]   shift_out;
  logic                    accept;
  logic                    clear;
  logic                    last_beat;

  // A start in LOAD wins over a beat presented in the same cycle.
  assign accept    = ready_q & data_valid & ~start;
  // Reload from DONE keeps the old shadow so it streams out to the next tile.
  assign clear     = start & ((state_q == StIdle) | (state_q == StLoad));
  assign last_beat = (count_q == CNT_W'(BEATS - 1));

  config_shift_register #(
    .WIDTH      (CONFIG_WIDTH),
    .SHIFT_WIDTH(DATA_WIDTH)
  ) u_shadow (
    .clock    (clock),
    .nreset   (nreset),
    .clear    (clear),
    .shift_en (accept),
    .data_in  (data_in),
    .shadow   (shadow),
    .shift_out(shift_out)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      chain_q  <= '0;
      config_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StLoad;
            count_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        StLoad: begin
          if (start) begin
            count_q <= '0;
          end else if (accept) begin
            count_q <= count_q + CNT_W'(1);
            chain_q <= shift_out;
            if (last_beat) begin
              state_q <= StCommit;
              ready_q <= 1'b0;
            end
          end
        end
        StCommit: begin
          config_q <= shadow;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_ready  = ready_q;
  assign chain_out   = chain_q;
  assign config_out  = config_q;
  assign config_done = done_q;
  assign busy        = busy_q;

endmodule
